// File: rtl/pc_sequencer.sv
// Program-flow controller: drives the PC register's next value, runs the fetch/execute
// handshake and resolves jump, branch, call/return and halt flow through a small return stack.
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             instr_valid,
  input  logic [2:0]       op,
  input  logic             cond,
  input  logic [WIDTH-1:0] target,
  input  logic             exec_done,
  input  logic             run,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    top_idx;
  logic             ras_full, ras_empty;
  logic             push, pop, overflow_set, underflow_set;
  logic             overflow_reg, underflow_reg;

  assign pc_inc    = pc_cur + {{(WIDTH-1){1'b0}}, 1'b1};
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign ras_empty = (count_reg == '0);
  assign top_idx   = AW'(count_reg - 1'b1);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_cur;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    case (state_reg)
      IDLE: begin
        pc_next    = RESET_VECTOR;
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_next = (op == OP_HALT) ? HALT : FETCH;
          case (op)
            OP_JMP:  pc_next = target;
            OP_BRZ:  pc_next = cond ? target : pc_inc;
            OP_CALL: begin
              pc_next      = target;
              push         = !ras_full;
              overflow_set = ras_full;
            end
            OP_RET: begin
              if (ras_empty) begin
                pc_next       = pc_inc;
                underflow_set = 1'b1;
              end else begin
                pc_next = ras[top_idx];
                pop     = 1'b1;
              end
            end
            default: pc_next = pc_inc;
          endcase
        end
      end
      HALT: begin
        if (run) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  assign halted        = (state_reg == HALT);
  assign ras_overflow  = overflow_reg;
  assign ras_underflow = underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) count_reg <= count_reg + 1'b1;
      else if (pop) count_reg <= count_reg - 1'b1;
      if (overflow_set)  overflow_reg  <= 1'b1;
      if (underflow_set) underflow_reg <= 1'b1;
    end
  end

  // Stack storage needs no reset: the count alone defines which entries are live.
  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    always_ff @(posedge clk) begin
      if (push && count_reg == CW'(gi)) ras[gi] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a behavioural PC/return-stack model predicts each
// fetch address, pc_next on exec_done and the sticky flags, alongside directed scenarios.
module tb_pc_sequencer;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_cur = 16'h0;
  logic [15:0] pc_next;
  logic        imem_req, imem_ack = 1'b0, instr_valid;
  logic [2:0]  op = 3'd0;
  logic        cond = 1'b0;
  logic [15:0] target = 16'h0;
  logic        exec_done = 1'b0, run = 1'b0;
  logic        halted, ras_overflow, ras_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] model_pc;
  logic [15:0] model_ras[$];
  logic        model_ovf, model_unf;

  pc_sequencer #(.WIDTH(16), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_valid(instr_valid),
    .op(op), .cond(cond), .target(target), .exec_done(exec_done), .run(run),
    .halted(halted), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer drives.
  always @(posedge clk) pc_cur <= pc_next;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_exec(input logic [2:0] o, input logic c,
                                             input logic [15:0] t);
    logic [15:0] nxt;
    case (o)
      3'd1: nxt = t;
      3'd2: nxt = c ? t : model_pc + 16'd1;
      3'd3: begin
        if (model_ras.size() < DEPTH) model_ras.push_back(model_pc + 16'd1);
        else model_ovf = 1'b1;
        nxt = t;
      end
      3'd4: begin
        if (model_ras.size() > 0) nxt = model_ras.pop_back();
        else begin
          model_unf = 1'b1;
          nxt = model_pc + 16'd1;
        end
      end
      default: nxt = model_pc + 16'd1;
    endcase
    return nxt;
  endfunction

  // Entered and left at a falling edge with the DUT in FETCH; leaves with the DUT in EXEC.
  task automatic fetch_phase(input int ack_delay);
    check_eq("fetch_req", imem_req, 1'b1);
    check_eq("fetch_pc", pc_cur, model_pc);
    for (int d = 0; d < ack_delay; d++) begin
      imem_ack = 1'b0;
      exec_done = 1'($urandom);
      run = 1'($urandom);
      #1;
      check_eq("wait_req", imem_req, 1'b1);
      check_eq("wait_valid", instr_valid, 1'b0);
      check_eq("wait_pc_hold", pc_next, model_pc);
      @(negedge clk);
      check_eq("wait_pc_stable", pc_cur, model_pc);
    end
    imem_ack = 1'b1;
    exec_done = 1'b0;
    run = 1'b0;
    #1;
    check_eq("ack_valid", instr_valid, 1'b1);
    check_eq("ack_pc_hold", pc_next, model_pc);
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic exec_phase(input logic [2:0] o, input logic c, input logic [15:0] t,
                            input int exec_delay, input int halt_cycles);
    logic [15:0] exp_next;
    for (int d = 0; d < exec_delay; d++) begin
      exec_done = 1'b0;
      imem_ack = 1'($urandom);
      op = 3'($urandom);
      #1;
      check_eq("exec_req", imem_req, 1'b0);
      check_eq("exec_valid", instr_valid, 1'b0);
      check_eq("exec_pc_hold", pc_next, model_pc);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    exec_done = 1'b1;
    op = o; cond = c; target = t;
    exp_next = model_exec(o, c, t);
    #1;
    check_eq("exec_pc_next", pc_next, exp_next);
    $display("[TB] instr pc=%h op=%0d cond=%0d target=%h next=%h depth=%0d",
             model_pc, o, c, t, pc_next, model_ras.size());
    model_pc = exp_next;
    @(negedge clk);
    exec_done = 1'b0;
    check_eq("ovf_flag", ras_overflow, model_ovf);
    check_eq("unf_flag", ras_underflow, model_unf);
    if (o == 3'd5) begin
      for (int h = 0; h < halt_cycles; h++) begin
        imem_ack = 1'($urandom);
        exec_done = 1'($urandom);
        #1;
        check_eq("halt_flag", halted, 1'b1);
        check_eq("halt_req", imem_req, 1'b0);
        check_eq("halt_pc", pc_next, model_pc);
        @(negedge clk);
      end
      imem_ack = 1'b0;
      exec_done = 1'b0;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check_eq("unhalt_flag", halted, 1'b0);
    end else begin
      check_eq("not_halted", halted, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [2:0] o, input logic c, input logic [15:0] t,
                           input int ack_delay, input int exec_delay, input int halt_cycles);
    fetch_phase(ack_delay);
    exec_phase(o, c, t, exec_delay, halt_cycles);
  endtask

  // Asynchronous reset pulse from any falling edge; returns in FETCH at RESET_VECTOR.
  task automatic do_reset();
    imem_ack = 1'b0; exec_done = 1'b0; run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_ovf", ras_overflow, 1'b0);
    check_eq("rst_unf", ras_underflow, 1'b0);
    check_eq("rst_pc_next", pc_next, RV);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RV;
    model_ras.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_pc = RV;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(3'd0, 1'b0, 16'h0, 0, 0, 0);
    run_instr(3'd6, 1'b0, 16'h0, 3, 0, 0);
    run_instr(3'd1, 1'b0, 16'hFFFF, 0, 1, 0);
    run_instr(3'd0, 1'b0, 16'h0, 0, 0, 0);
    check_eq("wrap_pc", model_pc, 16'h0000);
    run_instr(3'd2, 1'b1, 16'h0040, 0, 0, 0);
    run_instr(3'd2, 1'b0, 16'h1234, 1, 2, 0);
    run_instr(3'd1, 1'b0, 16'h0010, 0, 0, 0);
    run_instr(3'd5, 1'b0, 16'h0, 0, 0, 10);
    check_eq("halt_resume_pc", pc_cur, 16'h0011);

    for (int k = 1; k <= 5; k++) run_instr(3'd3, 1'b0, 16'(k * 256), 0, 0, 0);
    for (int k = 0; k < 5; k++) run_instr(3'd4, 1'b0, 16'h0, 0, 0, 0);

    do_reset();
    run_instr(3'd3, 1'b0, 16'h0200, 0, 0, 0);
    fetch_phase(1);
    do_reset();
    run_instr(3'd4, 1'b0, 16'h0, 0, 0, 0);
    check_eq("ret_after_reset_unf", ras_underflow, 1'b1);

    for (int n = 0; n < 80; n++) begin
      int r;
      logic [2:0] o;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    o = 3'd3;
        2, 3:    o = 3'd4;
        4:       o = 3'd5;
        default: o = 3'($urandom);
      endcase
      run_instr(o, 1'($urandom), 16'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
